// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared FSM state encoding and sizing helpers for the shift-add multiplier.
package seq_mult_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, STEP, DONE} state_t;
    localparam int DEFAULT_WIDTH = 32;
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/mult_iter_counter.sv
// mult_iter_counter: clearable iteration counter saturating at WIDTH; o_tc flags that the next increment reaches WIDTH.
module mult_iter_counter
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = cnt_w(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_inc,
    output logic [CW-1:0] o_count,
    output logic          o_tc
);
    logic [CW-1:0] r_count;
    always_ff @(posedge clk) begin
        if (reset || i_clear) r_count <= '0;
        else if (i_inc && r_count != CW'(WIDTH)) r_count <= r_count + CW'(1);
    end
    assign o_count = r_count;
    assign o_tc    = r_count == CW'(WIDTH - 1);
endmodule

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: control FSM sequencing load, shift / add-and-shift iterations and the start/done handshake.
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_start,
    input  logic                       i_abort,
    input  logic                       i_mplier_lsb,
    input  logic                       i_mplier_zero,
    output logic                       o_load,
    output logic                       o_clear_product,
    output logic                       o_shift,
    output logic                       o_add_shift,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [$clog2(WIDTH+1)-1:0] o_iter_count
);
    localparam int CW = cnt_w(WIDTH);
    state_t r_state, w_next;
    logic   w_exit, w_step, w_tc;
    mult_iter_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clear (o_load),
        .i_inc   (w_step),
        .o_count (o_iter_count),
        .o_tc    (w_tc)
    );
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end
    // abort outranks the zero check, which outranks issuing an iteration
    always_comb begin
        w_exit = EARLY_EXIT && i_mplier_zero;
        w_step = r_state == STEP && !i_abort && !w_exit;
        w_next = r_state;
        unique case (r_state)
            IDLE: w_next = i_start ? LOAD : IDLE;
            LOAD: w_next = i_abort ? IDLE : STEP;
            STEP: w_next = i_abort ? IDLE : (w_exit || w_tc) ? DONE : STEP;
            DONE: w_next = i_start ? LOAD : IDLE;
        endcase
    end
    assign o_load          = r_state == LOAD;
    assign o_clear_product = r_state == LOAD;
    assign o_busy          = r_state != IDLE;
    assign o_done          = r_state == DONE;
    assign o_shift         = w_step && !i_mplier_lsb;
    assign o_add_shift     = w_step && i_mplier_lsb;
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb_seq_mult_ctrl: scoreboard bench running EARLY_EXIT=0 and =1 controllers side by side on shared stimulus.
module tb_seq_mult_ctrl;
    typedef struct {
        int          start_cyc;
        int          k;
        logic [31:0] mask;
        int          done_off;
    } exp_t;

    logic        clk = 0;
    logic        reset, start, abort;
    logic [31:0] op;
    logic [1:0]  load, clr, shift, add, busy, done, lsb, zero;
    logic [5:0]  iter [2];
    logic [31:0] mreg [2];
    int          cyc = 0;
    int          total = 0, passes = 0;
    exp_t        q [2][$];
    bit   [1:0]  act = 0, chk_rst = 0, chk_ab = 0;
    int          ok [2], ab_k [2];
    logic [31:0] msk [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_mult_ctrl #(.WIDTH(32), .EARLY_EXIT(1'b0)) u0 (
        .clk(clk), .reset(reset), .i_start(start), .i_abort(abort),
        .i_mplier_lsb(lsb[0]), .i_mplier_zero(zero[0]),
        .o_load(load[0]), .o_clear_product(clr[0]), .o_shift(shift[0]), .o_add_shift(add[0]),
        .o_busy(busy[0]), .o_done(done[0]), .o_iter_count(iter[0]));
    seq_mult_ctrl #(.WIDTH(32), .EARLY_EXIT(1'b1)) u1 (
        .clk(clk), .reset(reset), .i_start(start), .i_abort(abort),
        .i_mplier_lsb(lsb[1]), .i_mplier_zero(zero[1]),
        .o_load(load[1]), .o_clear_product(clr[1]), .o_shift(shift[1]), .o_add_shift(add[1]),
        .o_busy(busy[1]), .o_done(done[1]), .o_iter_count(iter[1]));

    // multiplier shift register the controllers are steering
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            mreg[i] <= load[i] ? op : (shift[i] | add[i]) ? mreg[i] >> 1 : mreg[i];
    end
    assign lsb[0]  = mreg[0][0];
    assign lsb[1]  = mreg[1][0];
    assign zero[0] = mreg[0] == 0;
    assign zero[1] = mreg[1] == 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // reference: iterate over multiplier bits, stopping early once the rest is zero
    function automatic exp_t model(input logic [31:0] m, input bit ee, input int sc);
        exp_t e;
        e.start_cyc = sc;
        e.k = 0;
        e.mask = 0;
        for (int i = 0; i < 32; i++) begin
            if (ee && (m >> i) == 0) break;
            e.mask[i] = m[i];
            e.k++;
        end
        e.done_off = (e.k < 32) ? e.k + 3 : 34;
        return e;
    endfunction

    task automatic push(input logic [31:0] m, input int sc);
        for (int i = 0; i < 2; i++) q[i].push_back(model(m, i == 1, sc));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic issue(input logic [31:0] m, input bit hold);
        op = m;
        start = 1;
        push(m, cyc);
        tick(hold ? 2 : 1);
        start = 0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200 && busy != 0; n++) tick(1);
        chk("idle_timeout", busy, 0);
        tick(1);
        chk("queue_drained", q[0].size() + q[1].size(), 0);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (chk_rst[i]) begin
                chk("reset_outputs", {load[i], clr[i], shift[i], add[i], busy[i], done[i], iter[i]}, 0);
                chk_rst[i] = 0;
            end
            if (chk_ab[i]) begin
                chk("abort_idle", {busy[i], done[i]}, 0);
                chk("abort_iter_hold", iter[i], ab_k[i]);
                chk_ab[i] = 0;
            end
            if (reset) begin
                q[i].delete();
                act[i] = 0;
                chk_rst[i] = 1;
            end else begin
                if (load[i]) begin
                    chk("load_expected", q[i].size() != 0, 1);
                    if (q[i].size() != 0) chk("load_cycle", cyc, q[i][0].start_cyc + 1);
                    chk("clear_with_load", clr[i], 1);
                    act[i] = 1;
                    ok[i] = 0;
                    msk[i] = 0;
                end
                if (act[i] && abort && !done[i]) begin
                    if (q[i].size() != 0) void'(q[i].pop_front());
                    ab_k[i] = ok[i];
                    chk_ab[i] = 1;
                    act[i] = 0;
                end
                if (shift[i] | add[i]) begin
                    chk("strobe_legal", act[i] && !(shift[i] & add[i]) && ok[i] < 32, 1);
                    if (ok[i] < 32) msk[i][ok[i]] = add[i];
                    ok[i]++;
                end
                if (done[i]) begin
                    chk("done_expected", act[i] && q[i].size() != 0, 1);
                    if (q[i].size() != 0) begin
                        exp_t e;
                        e = q[i].pop_front();
                        chk("iterations", ok[i], e.k);
                        chk("add_mask", msk[i], e.mask);
                        chk("done_cycle", cyc - e.start_cyc, e.done_off);
                        chk("iter_count", iter[i], e.k);
                    end
                    act[i] = 0;
                end
            end
        end
    end

    initial begin
        int c;
        reset = 1;
        start = 0;
        abort = 0;
        op = 0;
        tick(3);
        reset = 0;
        issue(32'd5, 0);
        wait_idle();
        issue(32'd0, 0);
        wait_idle();
        issue(32'h8000_1234, 0);
        tick(10);
        abort = 1;
        tick(1);
        abort = 0;
        chk("abort_busy", busy, 0);
        chk("abort_iter0", iter[0], 9);
        chk("abort_iter1", iter[1], 9);
        wait_idle();
        issue(32'hC000_0001, 0);
        tick(19);
        reset = 1;
        tick(1);
        reset = 0;
        chk("reset_busy", busy, 0);
        chk("reset_iter", {iter[0], iter[1]}, 0);
        issue($urandom, 0);
        wait_idle();
        c = cyc;
        op = 32'hFFFF_FFFF;
        start = 1;
        push(op, c);
        tick(3);
        op = $urandom;
        push(op, c + 34);
        tick(31);
        chk("b2b_done", done, 2'b11);
        tick(1);
        start = 0;
        chk("b2b_load_busy", {load, busy}, 4'hF);
        wait_idle();
        for (int n = 0; n < 16; n++) begin
            issue($urandom >> $urandom_range(0, 32), $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) begin
                tick($urandom_range(0, 38));
                abort = 1;
                tick(1);
                abort = 0;
            end
            wait_idle();
        end
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
